decimal_keypad_debounce: RTL

DECIMAL_KEYPAD_DEBOUNCE -- requirements
Module: decimal_keypad_debounce

---
 rtl/decimal_keypad_debounce.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/decimal_keypad_debounce.sv
// Debounced one-hot decimal keypad front end that drives a decimal-to-BCD encoder.
// Optional auto-repeat while a key stays held: define KEY_REPEAT_EN.
module decimal_keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] keys,
    output logic [9:0] D,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);
    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

    state_e        state_q, state_d;
    logic [9:0]    sync1_q, ks_q;
    logic [9:0]    cand_q, cand_d;
    logic [9:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic          multi_q;
    logic [3:0]    ones;
    logic          one_hot;

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rpt_q, rpt_d;
`endif

    assign ones    = 4'($countones(ks_q));
    assign one_hot = (ones == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            ks_q    <= '0;
            state_q <= IDLE;
            cand_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples pre-edge values, like real flops.
            sync1_q <= keys;
            ks_q    <= sync1_q;
            state_q <= state_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            multi_q <= (ones > 4'd1);
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEY_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    cand_d  = ks_q;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (ks_q != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    code_d  = cand_q;
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = PRESSED;
`ifdef KEY_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (ks_q == 10'd0) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (rpt_q == RPT_LAST) begin
                        valid_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + CW'(1);
                    end
`else
                    state_d = PRESSED;
`endif
                end
            end
            RELEASE: begin
                // A bounce back to nonzero resumes the same press without a new strobe.
                if (ks_q != 10'd0) begin
                    state_d = PRESSED;
`ifdef KEY_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    held_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign D         = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign multi_key = multi_q;

endmodule
